// File: rtl/pipe_if_id_hazard.sv
// pipe_if_id_hazard
//   IF/ID pipeline register for the 5-stage MIPS pipeline. It also holds the
//   load-use hazard detector and the branch flush control. A saturating
//   counter records the number of stall cycles for performance debug.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-low reset
//   pc_i            PC+4 from IF
//   instr_i         fetched instruction
//   ex_memread_i    MemRead of the instruction in EX
//   ex_rt_i         rt field of the instruction in EX
//   branch_taken_i  branch resolved taken this cycle (MEM stage)
//   pc_o            registered PC+4 to ID
//   instr_o         registered instruction to ID
//   valid_o         registered; instr_o is a real instruction
//   pc_write_o      combinational; 0 = PC must hold
//   ctrl_bubble_o   combinational; 1 = ID/EX loads all-zero control fields
//   flush_o         combinational; flush for ID/EX and EX/MEM
//   stall_cnt_o     registered, saturating count of load-use stall cycles
module pipe_if_id_hazard #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic             pc_write_o,
  output logic             ctrl_bubble_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_match;
  logic rt_match;
  logic hazard;
  logic stall;

  // Both source fields are compared whatever the opcode. An instruction with
  // no rt source can therefore stall needlessly, which is harmless.
  // Register $0 is never a real dependency.
  assign rs_match = (ex_rt_i == instr_q[25:21]);
  assign rt_match = (ex_rt_i == instr_q[20:16]);
  assign hazard   = valid_q & ex_memread_i & (ex_rt_i != 5'd0) & (rs_match | rt_match);

  // A flush discards the dependent instruction, so it overrides the stall.
  assign stall = hazard & ~branch_taken_i;

  assign pc_write_o    = ~stall;
  assign ctrl_bubble_o = branch_taken_i | hazard;
  assign flush_o       = branch_taken_i;

  always_comb begin
    pc_d    = pc_i;
    instr_d = instr_i;
    valid_d = 1'b1;
    cnt_d   = cnt_q;
    if (branch_taken_i) begin
      pc_d    = 32'h0000_0000;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      // Hold at all-ones rather than wrapping back to zero.
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign valid_o     = valid_q;
  assign stall_cnt_o = cnt_q;

endmodule
